i2c_slave_recv: RTL and testbench
=================================

// Module: i2c_slave_recv
// PURPOSE
//  Downstream stage of the I2C master-write path: an I2C slave receiver that decodes
//  START, 7-bit device address + W, 8-bit inner register address and data bytes,
//  ACKs each matched byte and issues a one-cycle register-write strobe.
//  Lives on the target side of the simulated bus.
//  Oversamples scl/sda on the system clock, which is the same clock as the master.
//  Master SCL period is 24 clk: high for 12, low for 12.
// PARAMETERS
//  SLAVE_ADDR   7'h50  device address matched against the first byte[7:1]
//  SYNC_STAGES  2      synchroniser depth on scl/sda inputs (>=2)
// PORTS
//  clk       in    1  system clock
//  rst       in    1  reset; synchronous, active-high
//  scl       in    1  I2C clock from master
//  sda       inout 1  I2C data; slave only drives 0 or z (open-drain, bench pull-up)
//  wrValid   out   1  one-cycle strobe: wrAddr/wrData valid
//  wrAddr    out   8  inner register address of the write
//  wrData    out   8  data byte written
//  busy      out   1  high from detected START to STOP/abort
//  nackErr   out   1  one-cycle pulse when the address byte is not ours or R/W=1
// BEHAVIOUR
//  - Interface: one clock (clk); reset is synchronous and active-high (rst).
//  - Reset: state=IDLE, sda released (z), wrValid=0, wrAddr=0, wrData=0, busy=0,
//    nackErr=0, bit counter=0. Reset mid-transfer releases sda on the next clk edge.
//  - Inputs pass through SYNC_STAGES flops, then one history flop; edges are taken
//    from the synchronised values. Detection latency is SYNC_STAGES+1 clk.
//  - START = sda 1->0 while scl=1. STOP = sda 0->1 while scl=1. Both are
//    recognised in every state, including IDLE. A START inside a frame acts as a
//    repeated START: go to ADDR and clear the bit counter.
//  - Data bits are shifted MSB-first on each synced scl rising edge.
//    sda changes while scl=1 are handled only as START/STOP.
//  - FSM states: IDLE -> ADDR -> ADDR_ACK -> REG -> REG_ACK -> DATA -> DATA_ACK -> DATA ...
//    plus WAIT_STOP.
//    IDLE: wait for START; set busy=1.
//    ADDR: 8 bits. On the 8th bit, if byte[7:1]==SLAVE_ADDR and byte[0]==0, go to
//      ADDR_ACK. Otherwise pulse nackErr, keep sda released, go to WAIT_STOP.
//    *_ACK: on the scl falling edge after bit 8, drive sda=0. Hold it through the
//      scl high phase. Release on the next scl falling edge, then go to the next
//      byte state.
//    REG: 8 bits -> latch regPtr -> REG_ACK.
//    DATA: 8 bits -> in the same clk as the 8th rising edge, wrValid=1,
//      wrAddr=regPtr, wrData=byte -> DATA_ACK. regPtr then increments (8-bit wrap,
//      8'hFF -> 8'h00), so multi-byte writes land at consecutive addresses.
//    WAIT_STOP: sda released, ignore bits until STOP (-> IDLE) or START (-> ADDR).
//  - STOP in any state: -> IDLE, busy=0, sda released. A partial byte is discarded
//    and no wrValid is issued.
//  - The bit counter is 4 bits, cleared on START and on each byte boundary.
//  - wrValid and nackErr are never high in the same cycle. wrValid never pulses
//    twice for one byte.
// STRUCTURE
//  - Shared header i2cSlaveHeaders.vh holds:
//    state encodings (`sIdle, `sAddr, `sAddrAck, `sReg, `sRegAck, `sData,
//    `sDataAck, `sWaitStop);
//    the write-direction bit constant.
//  - One sub-module, i2c_line_sync: parameterised synchroniser plus edge detect.
//    Outputs: sclSync, sdaSync, sclRise, sclFall, startDet, stopDet.
//    The FSM, shift register, regPtr and sda drive stay in i2c_slave_recv.
// TESTING (bench: i2cSend master, pull-up on sda, SLAVE_ADDR=7'h50)
//  1. Master writes dev 7'h50, reg 8'h12, data 8'hA5 -> exactly one wrValid,
//     wrAddr=8'h12, wrData=8'hA5; master sees ack=0 for all three bytes;
//     busy falls after STOP.
//  2. Master addresses dev 7'h51 -> one nackErr pulse, sda never driven by the
//     slave, no wrValid, FSM ends in IDLE after STOP.
//  3. Bench BFM frame: 0xA0, reg 8'hFF, data 8'h01, 8'h02 -> two wrValid:
//     (8'hFF, 8'h01), then (8'h00, 8'h02).
//  4. STOP injected after 4 data bits -> no wrValid, busy=0, sda released,
//     next full frame decodes correctly.
//  5. Repeated START after the REG byte, followed by a new full frame to reg
//     8'h34, data 8'h5A -> single wrValid (8'h34, 8'h5A).
//  6. rst=1 asserted while slave drives ACK low -> sda is z next clk and all
//     outputs are at reset values.

Source files
------------

// File: rtl/i2c_slave_recv_pkg.sv
// rtl/i2c_slave_recv_pkg.sv - FSM state encodings and helpers shared by the I2C slave receiver.
package i2c_slave_recv_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_REG       = 3'd3;
  localparam logic [2:0] S_REG_ACK   = 3'd4;
  localparam logic [2:0] S_DATA      = 3'd5;
  localparam logic [2:0] S_DATA_ACK  = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  localparam logic DIR_WRITE = 1'b0;

  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
    return (addr_byte[7:1] == dev) && (addr_byte[0] == DIR_WRITE);
  endfunction

  // Byte state that follows each ACK slot.
  function automatic logic [2:0] after_ack(input logic [2:0] s);
    return (s == S_ADDR_ACK) ? S_REG : S_DATA;
  endfunction

endpackage

// File: rtl/i2c_slave_recv_line_sync.sv
// rtl/i2c_slave_recv_line_sync.sv - scl/sda synchroniser with edge, START and STOP detection.
module i2c_slave_recv_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sclSync,
  output logic sdaSync,
  output logic sclRise,
  output logic sclFall,
  output logic startDet,
  output logic stopDet
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic scl_prev;
  logic sda_prev;

  // Reset to the idle-bus level so no edge is seen when reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda};
      scl_prev <= scl_pipe[SYNC_STAGES-1];
      sda_prev <= sda_pipe[SYNC_STAGES-1];
    end
  end

  assign sclSync  = scl_pipe[SYNC_STAGES-1];
  assign sdaSync  = sda_pipe[SYNC_STAGES-1];
  assign sclRise  = sclSync & ~scl_prev;
  assign sclFall  = ~sclSync & scl_prev;
  assign startDet = sclSync & scl_prev & sda_prev & ~sdaSync;
  assign stopDet  = sclSync & scl_prev & ~sda_prev & sdaSync;

endmodule

// File: rtl/i2c_slave_recv.sv
// rtl/i2c_slave_recv.sv - I2C slave receiver decoding address, register pointer and write data.
module i2c_slave_recv
  import i2c_slave_recv_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       wrValid,
  output logic [7:0] wrAddr,
  output logic [7:0] wrData,
  output logic       busy,
  output logic       nackErr
);

  logic scl_sync, sda_sync, scl_rise, scl_fall, start_det, stop_det;
  logic unused_scl_level;

  i2c_slave_recv_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .sclSync  (scl_sync),
    .sdaSync  (sda_sync),
    .sclRise  (scl_rise),
    .sclFall  (scl_fall),
    .startDet (start_det),
    .stopDet  (stop_det)
  );

  assign unused_scl_level = scl_sync;

  logic [2:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] reg_ptr;
  logic       sda_low;
  logic [7:0] byte_next;

  assign byte_next = {shreg[6:0], sda_sync};
  assign sda = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 8'd0;
      reg_ptr <= 8'd0;
      sda_low <= 1'b0;
      wrValid <= 1'b0;
      wrAddr  <= 8'd0;
      wrData  <= 8'd0;
      busy    <= 1'b0;
      nackErr <= 1'b0;
    end else begin
      wrValid <= 1'b0;
      nackErr <= 1'b0;
      if (stop_det) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        sda_low <= 1'b0;
        bit_cnt <= 4'd0;
      end else if (start_det) begin
        state   <= S_ADDR;
        busy    <= 1'b1;
        sda_low <= 1'b0;
        bit_cnt <= 4'd0;
      end else begin
        case (state)
          S_ADDR, S_REG, S_DATA: begin
            if (scl_rise) begin
              shreg   <= byte_next;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (state == S_ADDR) begin
                  if (addr_match(byte_next, SLAVE_ADDR)) begin
                    state <= S_ADDR_ACK;
                  end else begin
                    nackErr <= 1'b1;
                    state   <= S_WAIT_STOP;
                  end
                end else if (state == S_REG) begin
                  reg_ptr <= byte_next;
                  state   <= S_REG_ACK;
                end else begin
                  wrValid <= 1'b1;
                  wrAddr  <= reg_ptr;
                  wrData  <= byte_next;
                  reg_ptr <= reg_ptr + 8'd1;
                  state   <= S_DATA_ACK;
                end
              end
            end
          end
          // First scl fall after bit 8 pulls sda low, the following fall lets it go.
          S_ADDR_ACK, S_REG_ACK, S_DATA_ACK: begin
            if (scl_fall) begin
              if (!sda_low) begin
                sda_low <= 1'b1;
              end else begin
                sda_low <= 1'b0;
                state   <= after_ack(state);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_recv.sv
// tb/tb_i2c_slave_recv.sv - I2C master BFM driving i2c_slave_recv, checked against a frame-level model.
module tb_i2c_slave_recv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  sda;
  logic       wrValid;
  logic [7:0] wrAddr;
  logic [7:0] wrData;
  logic       busy;
  logic       nackErr;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_recv #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl     (scl),
    .sda     (sda),
    .wrValid (wrValid),
    .wrAddr  (wrAddr),
    .wrData  (wrData),
    .busy    (busy),
    .nackErr (nackErr)
  );

  int checks = 0;
  int failures = 0;
  int nack_exp = 0;
  int nack_seen = 0;
  int wr_seen = 0;
  bit slave_acks = 1'b0;
  bit run = 1'b0;
  logic [15:0] exp_q[$];
  logic [7:0] fdata[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run && !rst) begin
      chk("strobe_exclusive", {31'd0, wrValid & nackErr}, 32'd0);
      if (wrValid) begin
        logic [15:0] e;
        wr_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0h/%0h required=none", wrAddr, wrData);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {24'd0, wrAddr}, {24'd0, e[15:8]});
          chk("wr_data", {24'd0, wrData}, {24'd0, e[7:0]});
        end
      end
      if (nackErr) nack_seen++;
      if (!m_low && !slave_acks) chk("slave_not_driving", {31'd0, sda}, 32'd1);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; scl = 1'b1; wait_clk(12);
    m_low = 1'b1; wait_clk(6);
    scl = 1'b0; wait_clk(6);
  endtask

  task automatic i2c_rstart();
    m_low = 1'b0; wait_clk(6);
    scl = 1'b1; wait_clk(6);
    m_low = 1'b1; wait_clk(6);
    scl = 1'b0; wait_clk(6);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_clk(6);
    scl = 1'b1; wait_clk(12);
    m_low = 1'b0; wait_clk(12);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input bit acks);
    for (int i = 0; i < n; i++) begin
      m_low = !b[7-i]; wait_clk(6);
      scl = 1'b1; wait_clk(12);
      if (i == 7) slave_acks = acks;
      scl = 1'b0; wait_clk(6);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit acks, input bit do_rst);
    logic ack;
    send_bits(b, 8, acks);
    m_low = 1'b0; wait_clk(6);
    scl = 1'b1; wait_clk(6);
    if (do_rst) begin
      chk("rst_ack_driven", {31'd0, sda}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_sda_released", {31'd0, sda}, 32'd1);
      chk("rst_wrValid", {31'd0, wrValid}, 32'd0);
      chk("rst_wrAddr", {24'd0, wrAddr}, 32'd0);
      chk("rst_wrData", {24'd0, wrData}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_nackErr", {31'd0, nackErr}, 32'd0);
      rst = 1'b0;
    end
    ack = sda;
    if (!do_rst) chk("master_ack", {31'd0, ack}, {31'd0, !acks});
    wait_clk(6);
    scl = 1'b0; wait_clk(6);
    slave_acks = 1'b0;
  endtask

  // Frame-level model: matched address gets ACKs and writes at r, r+1, ...;
  // anything else is one NACK; an aborted last byte produces no write.
  task automatic frame(input logic [7:0] a, input logic [7:0] r, input int nd, input int abort_bits);
    bit ok;
    ok = (a[7:1] == 7'h50) && (a[0] == 1'b0);
    i2c_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    send_byte(a, ok, 1'b0);
    if (ok) begin
      send_byte(r, 1'b1, 1'b0);
      for (int i = 0; i < nd; i++) begin
        if (i == nd - 1 && abort_bits > 0) begin
          send_bits(fdata[i], abort_bits, 1'b0);
        end else begin
          exp_q.push_back({8'(r + 8'(i)), fdata[i]});
          send_byte(fdata[i], 1'b1, 1'b0);
        end
      end
    end else begin
      nack_exp++;
    end
    i2c_stop();
    wait_clk(4);
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
    chk("sda_idle", {31'd0, sda}, 32'd1);
  endtask

  initial begin
    wait_clk(4);
    chk("reset_wrValid", {31'd0, wrValid}, 32'd0);
    chk("reset_wrAddr", {24'd0, wrAddr}, 32'd0);
    chk("reset_wrData", {24'd0, wrData}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_nackErr", {31'd0, nackErr}, 32'd0);
    chk("reset_sda", {31'd0, sda}, 32'd1);
    rst = 1'b0;
    run = 1'b1;
    wait_clk(4);

    fdata[0] = 8'hA5;
    frame(8'hA0, 8'h12, 1, 0);
    chk("t1_wrAddr", {24'd0, wrAddr}, 32'h12);
    chk("t1_wrData", {24'd0, wrData}, 32'hA5);
    chk("t1_count", wr_seen, 1);

    frame(8'hA2, 8'h12, 1, 0);
    chk("t2_nack_count", nack_seen, 1);
    chk("t2_count", wr_seen, 1);

    fdata[0] = 8'h01; fdata[1] = 8'h02;
    frame(8'hA0, 8'hFF, 2, 0);
    chk("t3_wrAddr", {24'd0, wrAddr}, 32'h00);
    chk("t3_wrData", {24'd0, wrData}, 32'h02);
    chk("t3_count", wr_seen, 3);

    fdata[0] = 8'hC3;
    frame(8'hA0, 8'h20, 1, 4);
    chk("t4_count", wr_seen, 3);
    fdata[0] = 8'h3C;
    frame(8'hA0, 8'h21, 1, 0);
    chk("t4_wrAddr", {24'd0, wrAddr}, 32'h21);
    chk("t4_count_after", wr_seen, 4);

    i2c_start();
    send_byte(8'hA0, 1'b1, 1'b0);
    send_byte(8'h77, 1'b1, 1'b0);
    i2c_rstart();
    send_byte(8'hA0, 1'b1, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0);
    exp_q.push_back(16'h345A);
    send_byte(8'h5A, 1'b1, 1'b0);
    i2c_stop();
    wait_clk(4);
    chk("t5_wrAddr", {24'd0, wrAddr}, 32'h34);
    chk("t5_wrData", {24'd0, wrData}, 32'h5A);
    chk("t5_count", wr_seen, 5);

    i2c_start();
    send_byte(8'hA0, 1'b1, 1'b1);
    i2c_stop();
    wait_clk(4);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    fdata[0] = 8'h99;
    frame(8'hA0, 8'h66, 1, 0);
    chk("t6_recover_wrData", {24'd0, wrData}, 32'h99);

    for (int n = 0; n < 20; n++) begin
      logic [7:0] a;
      logic [7:0] r;
      int nd;
      int ab;
      a  = ($urandom % 4 == 0) ? 8'($urandom) : 8'hA0;
      r  = 8'($urandom);
      nd = $urandom_range(0, 3);
      ab = (nd > 0 && $urandom % 3 == 0) ? $urandom_range(1, 6) : 0;
      for (int k = 0; k < 4; k++) fdata[k] = 8'($urandom);
      frame(a, r, nd, ab);
    end

    wait_clk(10);
    chk("expected_writes_drained", exp_q.size(), 0);
    chk("nack_total", nack_seen, nack_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
